// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side bundle for branch_predict_unit: the IF prediction read, the EX
// resolution inputs, and the registered mispredict redirect.
interface branch_predict_unit_if #(
   parameter int PC_W = 32
) ();
   logic [PC_W-1:0] if_pc;
   logic            if_pred_taken;
   logic            ex_valid;
   logic            ex_branch;
   logic [4:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic [PC_W-1:0] ex_pc;
   logic            ex_pred_taken;
   logic            ex_zero;
   logic            ex_sign;
   logic            ex_overflow;
   logic            ex_carry;
   logic            ex_taken;
   logic            mispredict;
   logic            mispredict_taken;

   modport master (
      output if_pc, ex_valid, ex_branch, ex_opcode, ex_funct3, ex_pc, ex_pred_taken,
             ex_zero, ex_sign, ex_overflow, ex_carry,
      input  if_pred_taken, ex_taken, mispredict, mispredict_taken
   );

   modport slave (
      input  if_pc, ex_valid, ex_branch, ex_opcode, ex_funct3, ex_pc, ex_pred_taken,
             ex_zero, ex_sign, ex_overflow, ex_carry,
      output if_pred_taken, ex_taken, mispredict, mispredict_taken
   );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32 branch resolution from ALU flags plus a direct-mapped 2-bit counter predictor.
// Optional BP_STATS_EN adds br_count/mispredict_count statistics outputs.
module branch_predict_unit #(
   parameter int         IDX_W    = 6,
   parameter int         PC_W     = 32,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_predict_unit_if.slave bp
`ifdef BP_STATS_EN
   ,
   output logic [31:0]          br_count,
   output logic [31:0]          mispredict_count
`endif
);
   localparam int ENTRIES = 1 << IDX_W;

   function automatic logic resolve(input logic [2:0] f3, input logic z, input logic s,
                                    input logic v, input logic c);
      logic t;
      case (f3)
         3'b000:  t = z;
         3'b001:  t = !z;
         3'b100:  t = s ^ v;
         3'b101:  t = !(s ^ v);
         3'b110:  t = !c;
         3'b111:  t = c;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   function automatic logic legal_f3(input logic [2:0] f3);
      return (f3 != 3'b010) && (f3 != 3'b011);
   endfunction

   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
      logic [1:0] n;
      if (up) n = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
      else    n = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
      return n;
   endfunction

   logic [1:0]       cnt_q [ENTRIES];
   logic             mispredict_q, mispredict_d;
   logic             mp_taken_q, mp_taken_d;
   logic             br;
   logic             taken;
   logic             upd_en;
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [1:0]       cnt_d;

   always_comb begin
      br           = bp.ex_valid & bp.ex_branch & (bp.ex_opcode == 5'b11000);
      taken        = br ? resolve(bp.ex_funct3, bp.ex_zero, bp.ex_sign,
                                  bp.ex_overflow, bp.ex_carry) : 1'b0;
      upd_en       = br & legal_f3(bp.ex_funct3);
      if_idx       = bp.if_pc[IDX_W+1:2];
      ex_idx       = bp.ex_pc[IDX_W+1:2];
      cnt_d        = sat_step(cnt_q[ex_idx], taken);
      mispredict_d = br & (taken != bp.ex_pred_taken);
      mp_taken_d   = taken;
   end

   // The IF read is taken straight from the table: a same-cycle update is not bypassed.
   assign bp.if_pred_taken    = cnt_q[if_idx][1];
   assign bp.ex_taken         = taken;
   assign bp.mispredict       = mispredict_q;
   assign bp.mispredict_taken = mp_taken_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
         mispredict_q <= 1'b0;
         mp_taken_q   <= 1'b0;
      end else begin
         if (upd_en) cnt_q[ex_idx] <= cnt_d;
         mispredict_q <= mispredict_d;
         mp_taken_q   <= mp_taken_d;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] br_count_q, br_count_d;
   logic [31:0] mp_count_q, mp_count_d;

   always_comb begin
      br_count_d = br_count_q + {31'd0, br};
      mp_count_d = mp_count_q + {31'd0, mispredict_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count_q <= 32'd0;
         mp_count_q <= 32'd0;
      end else begin
         br_count_q <= br_count_d;
         mp_count_q <= mp_count_d;
      end
   end

   assign br_count         = br_count_q;
   assign mispredict_count = mp_count_q;
`endif

   // PC bits outside the index field carry no information for a tagless table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.if_pc[PC_W-1:IDX_W+2], bp.if_pc[1:0],
                             bp.ex_pc[PC_W-1:IDX_W+2], bp.ex_pc[1:0]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit; flags derived from rs1-rs2 operands.
module tb_branch_predict_unit;
   localparam int IDX_W = 6;
   localparam int PC_W  = 32;
   localparam int ENT   = 1 << IDX_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.PC_W(PC_W)) bp ();
`ifdef BP_STATS_EN
   logic [31:0] br_count, mispredict_count;
`endif

   branch_predict_unit #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_INIT(2'b01)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp)
`ifdef BP_STATS_EN
      ,
      .br_count         (br_count),
      .mispredict_count (mispredict_count)
`endif
   );

   int          errors = 0;
   int          checks = 0;
   logic [1:0]  mcnt [ENT];
   logic [1:0]  sb_q [$];
   logic [31:0] m_br, m_mp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENT; i++) mcnt[i] = 2'b01;
      m_br = 0;
      m_mp = 0;
      sb_q.delete();
   endtask

   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'(pc[IDX_W+1:2]);
   endfunction

   task automatic ex_step(input string tag, input logic v, input logic b, input logic [4:0] op,
                          input logic [2:0] f3, input logic [31:0] pc, input logic pred,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] ipc);
      logic [32:0] diff;
      logic        br, t, mp;
      logic [1:0]  pk;
      int          ei;
      diff = {1'b0, rs1} - {1'b0, rs2};
      bp.if_pc         = ipc;
      bp.ex_valid      = v;
      bp.ex_branch     = b;
      bp.ex_opcode     = op;
      bp.ex_funct3     = f3;
      bp.ex_pc         = pc;
      bp.ex_pred_taken = pred;
      bp.ex_zero       = (diff[31:0] == 32'd0);
      bp.ex_sign       = diff[31];
      bp.ex_overflow   = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
      bp.ex_carry      = ~diff[32];
      #1;
      br = v & b & (op == 5'b11000);
      t  = br ? ref_taken(f3, rs1, rs2) : 1'b0;
      mp = br & (t != pred);
      chk({tag, "_taken"}, {31'd0, bp.ex_taken}, {31'd0, t});
      chk({tag, "_pred"}, {31'd0, bp.if_pred_taken}, {31'd0, mcnt[idx_of(ipc)][1]});
      sb_q.push_back({mp, t});
      @(posedge clk);
      ei = idx_of(pc);
      if (br && f3 != 3'b010 && f3 != 3'b011) begin
         if (t) mcnt[ei] = (mcnt[ei] == 2'b11) ? 2'b11 : mcnt[ei] + 2'd1;
         else   mcnt[ei] = (mcnt[ei] == 2'b00) ? 2'b00 : mcnt[ei] - 2'd1;
      end
      if (br) m_br = m_br + 1;
      if (mp) m_mp = m_mp + 1;
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         pk = sb_q.pop_front();
         chk({tag, "_mp"}, {31'd0, bp.mispredict}, {31'd0, pk[1]});
         chk({tag, "_mpt"}, {31'd0, bp.mispredict_taken}, {31'd0, pk[0]});
      end
`ifdef BP_STATS_EN
      chk({tag, "_brcnt"}, br_count, m_br);
      chk({tag, "_mpcnt"}, mispredict_count, m_mp);
`endif
   endtask

   task automatic idle_step(input string tag, input logic [31:0] ipc);
      ex_step(tag, 1'b0, 1'b0, 5'b00000, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, ipc);
   endtask

   localparam logic [4:0] BR = 5'b11000;

   initial begin
      logic [2:0]  f3s [7];
      logic [31:0] a, b;
      f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
      model_reset();
      rst = 1'b1;
      bp.if_pc = 32'h40; bp.ex_valid = 0; bp.ex_branch = 0; bp.ex_opcode = 0;
      bp.ex_funct3 = 0; bp.ex_pc = 0; bp.ex_pred_taken = 0; bp.ex_zero = 0;
      bp.ex_sign = 0; bp.ex_overflow = 0; bp.ex_carry = 0;
      #12;
      chk("rst_mp", {31'd0, bp.mispredict}, 32'd0);
      chk("rst_mpt", {31'd0, bp.mispredict_taken}, 32'd0);
      chk("rst_pred40", {31'd0, bp.if_pred_taken}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Signed-overflow case: 0x7FFFFFFF vs -1.
      ex_step("blt_ovf", 1, 1, BR, 3'b100, 32'h80, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h40);
      ex_step("bge_ovf", 1, 1, BR, 3'b101, 32'h80, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h40);
      idle_step("after_bge", 32'h40);

      ex_step("beq1", 1, 1, BR, 3'b000, 32'h100, 0, 32'h5, 32'h5, 32'h100);
      ex_step("beq2", 1, 1, BR, 3'b000, 32'h100, 1, 32'h5, 32'h5, 32'h100);
      ex_step("beq3", 1, 1, BR, 3'b000, 32'h100, 1, 32'h5, 32'h5, 32'h100);
      ex_step("beq_nt", 1, 1, BR, 3'b000, 32'h100, 1, 32'h5, 32'h6, 32'h100);
      idle_step("beq_after", 32'h100);
      chk("beq_cnt_taken", {31'd0, bp.if_pred_taken}, 32'd1);

      // Same-cycle IF read and EX update of index 5.
      ex_step("same_idx", 1, 1, BR, 3'b000, 32'h14, 0, 32'h9, 32'h9, 32'h14);
      idle_step("same_idx_next", 32'h14);
      chk("same_idx_new", {31'd0, bp.if_pred_taken}, 32'd1);

      ex_step("squashed", 0, 1, BR, 3'b000, 32'h200, 0, 32'h1, 32'h1, 32'h200);
      ex_step("not_branch", 1, 1, 5'b01100, 3'b000, 32'h200, 1, 32'h1, 32'h1, 32'h200);
      ex_step("illegal_f3", 1, 1, BR, 3'b010, 32'h200, 1, 32'h1, 32'h1, 32'h200);
      idle_step("illegal_chk", 32'h200);

      for (int i = 0; i < 40; i++) begin
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         if ($urandom_range(0, 4) == 0) a = {~b[31], a[30:0]};
         ex_step($sformatf("rnd%0d", i), 1'b1, 1'b1, BR, f3s[$urandom_range(0, 6)],
                 32'h300 + 32'($urandom_range(0, 3)) * 4, 1'($urandom_range(0, 1)), a, b,
                 32'h300 + 32'($urandom_range(0, 3)) * 4);
      end

      // Asynchronous reset while a mispredict pulse is pending on the output.
      ex_step("pre_rst", 1, 1, BR, 3'b000, 32'h100, 0, 32'h7, 32'h7, 32'h100);
      bp.ex_valid = 1'b0;
      bp.if_pc = 32'h100;
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("midrst_mp", {31'd0, bp.mispredict}, 32'd0);
      chk("midrst_mpt", {31'd0, bp.mispredict_taken}, 32'd0);
      chk("midrst_pred", {31'd0, bp.if_pred_taken}, 32'd0);
`ifdef BP_STATS_EN
      chk("midrst_brcnt", br_count, 32'd0);
      chk("midrst_mpcnt", mispredict_count, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      idle_step("post_rst", 32'h100);
      ex_step("post_rst_br", 1, 1, BR, 3'b001, 32'h100, 0, 32'h1, 32'h2, 32'h100);
      idle_step("post_rst_end", 32'h100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
